// File: rtl/stage_execute_mdu.sv
// rtl/stage_execute_mdu.sv - execute stage: single-cycle ALU plus optional iterative multiply/divide unit
// Build with EX_MDU_EN defined to include the MDU; otherwise ex_mdu/ex_mdu_op are ignored.
module stage_execute_mdu #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic [XLEN-1:0]   ex_pc,
  input  logic [XLEN-1:0]   ex_rdata1,
  input  logic [XLEN-1:0]   ex_rdata2,
  input  logic [XLEN-1:0]   ex_imm,
  input  logic              ex_use_pc0,
  input  logic              ex_use_pc1,
  input  logic              ex_use_imm,
  input  logic              ex_sub_sra,
  input  logic              ex_jmp,
  input  logic              ex_br,
  input  logic [3:0]        ex_op,
  input  logic              ex_mdu,
  input  logic [2:0]        ex_mdu_op,
  input  logic [CTRL_W-1:0] ex_ctrl,
  input  logic              ex_flush,
  input  logic              mem_stall,
  output logic              ex_stall,
  output logic              ex_busy,
  output logic              mem_valid,
  output logic [XLEN-1:0]   mem_pc,
  output logic [XLEN-1:0]   mem_data0,
  output logic [XLEN-1:0]   mem_data1,
  output logic [CTRL_W-1:0] mem_ctrl
);

  localparam int LOGX = $clog2(XLEN);

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SEQ  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_SLTU = 4'd7;
  localparam logic [3:0] OP_SL   = 4'd8;
  localparam logic [3:0] OP_SR   = 4'd9;

  logic [XLEN-1:0]        op1, op2, addend, alu_res, data1_d, data0_d;
  logic signed [XLEN-1:0] sra_res;
  logic [LOGX-1:0]        shamt;
  logic                   valid_d;

  logic              mem_valid_q;
  logic [XLEN-1:0]   mem_pc_q, mem_data0_q, mem_data1_q;
  logic [CTRL_W-1:0] mem_ctrl_q;

  always_comb begin
    op1     = ex_use_pc0 ? ex_pc : ex_rdata1;
    op2     = ex_jmp ? XLEN'(4) : (ex_use_imm ? ex_imm : ex_rdata2);
    shamt   = op2[LOGX-1:0];
    addend  = ex_sub_sra ? (~op2 + XLEN'(1)) : op2;
    sra_res = $signed(op1) >>> shamt;
    case (ex_op)
      OP_NOP:  alu_res = '0;
      OP_ADD:  alu_res = op1 + addend;
      OP_AND:  alu_res = op1 & op2;
      OP_OR:   alu_res = op1 | op2;
      OP_XOR:  alu_res = op1 ^ op2;
      OP_SEQ:  alu_res = {{(XLEN-1){1'b0}}, op1 == op2};
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(op1) < $signed(op2)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, op1 < op2};
      OP_SL:   alu_res = op1 << shamt;
      OP_SR:   alu_res = ex_sub_sra ? sra_res : (op1 >> shamt);
      default: alu_res = '0;
    endcase
    data1_d = (ex_jmp | ex_br) ? (ex_imm + (ex_use_pc1 ? ex_pc : ex_rdata1)) : ex_rdata2;
  end

`ifdef EX_MDU_EN
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [LOGX:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d, dvz_q, dvz_d;

  logic              sa, sb, a_neg, b_neg, div_ge, mdu_done;
  logic [XLEN-1:0]   a_mag, b_mag, rem_step, quo_fix, rem_fix, mdu_res;
  logic [XLEN:0]     mul_sum, div_sh;
  logic [2*XLEN-1:0] prod;

  // Signedness per op: MUL/MULH/DIV/REM signed, MULHSU signed*unsigned, rest unsigned.
  assign sa    = ex_mdu_op[2] ? ~ex_mdu_op[0] : (ex_mdu_op[1:0] != 2'b11);
  assign sb    = ex_mdu_op[2] ? ~ex_mdu_op[0] : ~ex_mdu_op[1];
  assign a_neg = sa & op1[XLEN-1];
  assign b_neg = sb & op2[XLEN-1];
  assign a_mag = a_neg ? -op1 : op1;
  assign b_mag = b_neg ? -op2 : op2;

  // acc holds {product hi, multiplier} or {partial remainder, dividend/quotient}.
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
  assign div_sh   = acc_q[2*XLEN-1:XLEN-1];
  assign div_ge   = div_sh >= {1'b0, dvs_q};
  assign rem_step = div_ge ? (div_sh[XLEN-1:0] - dvs_q) : div_sh[XLEN-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    dvs_d   = dvs_q;
    op_d    = op_q;
    neg_d   = neg_q;
    dvz_d   = dvz_q;
    case (state_q)
      S_IDLE: begin
        if (ex_valid && ex_mdu) begin
          state_d = S_BUSY;
          cnt_d   = '0;
          op_d    = ex_mdu_op;
          acc_d   = {{XLEN{1'b0}}, ex_mdu_op[2] ? a_mag : b_mag};
          dvs_d   = ex_mdu_op[2] ? b_mag : a_mag;
          neg_d   = (ex_mdu_op[2] & ex_mdu_op[1]) ? a_neg : (a_neg ^ b_neg);
          dvz_d   = (op2 == '0);
        end
      end
      S_BUSY: begin
        acc_d = op_q[2] ? {rem_step, acc_q[XLEN-2:0], div_ge}
                        : {mul_sum, acc_q[XLEN-1:1]};
        if (cnt_q == (LOGX+1)'(XLEN-1)) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + (LOGX+1)'(1);
        end
      end
      S_DONE: if (!mem_stall) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (ex_flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    acc_q <= acc_d;
    dvs_q <= dvs_d;
    op_q  <= op_d;
    neg_q <= neg_d;
    dvz_q <= dvz_d;
  end

  assign prod    = neg_q ? -acc_q : acc_q;
  assign quo_fix = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem_fix = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  always_comb begin
    case (op_q)
      3'd0:             mdu_res = prod[XLEN-1:0];
      3'd1, 3'd2, 3'd3: mdu_res = prod[2*XLEN-1:XLEN];
      3'd4, 3'd5:       mdu_res = dvz_q ? '1 : quo_fix;
      default:          mdu_res = rem_fix;
    endcase
  end

  assign mdu_done = (state_q == S_DONE);
  assign valid_d  = ex_valid & ~ex_flush & (~ex_mdu | mdu_done);
  assign data0_d  = (ex_mdu & mdu_done) ? mdu_res : alu_res;
  assign ex_stall = ex_valid & (mem_stall | (ex_mdu & ~mdu_done));
  assign ex_busy  = (state_q != S_IDLE);
`else
  logic unused_mdu;
  assign unused_mdu = ^{ex_mdu, ex_mdu_op};
  assign valid_d    = ex_valid & ~ex_flush;
  assign data0_d    = alu_res;
  assign ex_stall   = ex_valid & mem_stall;
  assign ex_busy    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid_q <= 1'b0;
    end else if (!mem_stall) begin
      mem_valid_q <= valid_d;
    end
  end

  // Payload registers are don't-care while mem_valid is low, so they carry no reset.
  always_ff @(posedge clk) begin
    if (!mem_stall) begin
      mem_pc_q    <= ex_pc;
      mem_data0_q <= data0_d;
      mem_data1_q <= data1_d;
      mem_ctrl_q  <= ex_ctrl;
    end
  end

  assign mem_valid = mem_valid_q;
  assign mem_pc    = mem_pc_q;
  assign mem_data0 = mem_data0_q;
  assign mem_data1 = mem_data1_q;
  assign mem_ctrl  = mem_ctrl_q;

endmodule

// File: tb/tb_stage_execute_mdu.sv
// tb/tb_stage_execute_mdu.sv - directed self-checking bench for stage_execute_mdu
module tb_stage_execute_mdu;

  localparam logic [3:0] ADD = 4'd1, AND = 4'd2, XOR = 4'd4, SEQ = 4'd5,
                         SLT = 4'd6, SLTU = 4'd7, SL = 4'd8, SR = 4'd9;

  logic        clk = 1'b0;
  logic        reset, ex_valid, ex_use_pc0, ex_use_pc1, ex_use_imm, ex_sub_sra;
  logic        ex_jmp, ex_br, ex_mdu, ex_flush, mem_stall;
  logic [31:0] ex_pc, ex_rdata1, ex_rdata2, ex_imm;
  logic [3:0]  ex_op;
  logic [2:0]  ex_mdu_op;
  logic [12:0] ex_ctrl;
  logic        ex_stall, ex_busy, mem_valid;
  logic [31:0] mem_pc, mem_data0, mem_data1;
  logic [12:0] mem_ctrl;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stage_execute_mdu #(.XLEN(32), .CTRL_W(13)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm),
    .ex_use_pc0(ex_use_pc0), .ex_use_pc1(ex_use_pc1), .ex_use_imm(ex_use_imm),
    .ex_sub_sra(ex_sub_sra), .ex_jmp(ex_jmp), .ex_br(ex_br), .ex_op(ex_op),
    .ex_mdu(ex_mdu), .ex_mdu_op(ex_mdu_op), .ex_ctrl(ex_ctrl), .ex_flush(ex_flush),
    .mem_stall(mem_stall), .ex_stall(ex_stall), .ex_busy(ex_busy),
    .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_data0(mem_data0),
    .mem_data1(mem_data1), .mem_ctrl(mem_ctrl)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    ex_valid = 0; ex_use_pc0 = 0; ex_use_pc1 = 0; ex_use_imm = 0; ex_sub_sra = 0;
    ex_jmp = 0; ex_br = 0; ex_mdu = 0; ex_flush = 0; mem_stall = 0;
    ex_pc = 32'h0000_0040; ex_rdata1 = 0; ex_rdata2 = 0; ex_imm = 0;
    ex_op = ADD; ex_mdu_op = 0; ex_ctrl = 13'h1A5A;
  endtask

  task automatic alu(input logic [3:0] op, input logic sub, input logic [31:0] a, input logic [31:0] b);
    ex_op = op; ex_sub_sra = sub; ex_rdata1 = a; ex_rdata2 = b; ex_mdu = 0; ex_valid = 1;
    step();
    ex_valid = 0; ex_sub_sra = 0;
  endtask

  task automatic mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     output int lat, output logic [31:0] res);
    ex_mdu = 1; ex_mdu_op = op; ex_rdata1 = a; ex_rdata2 = b; ex_valid = 1;
    lat = -1; res = 'x;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (mem_valid) begin
        lat = i; res = mem_data0;
        break;
      end
    end
    ex_valid = 0; ex_mdu = 0;
  endtask

  initial begin
    int          lat;
    logic [31:0] res;
    logic        seen;
    clear();
    reset = 1; ex_valid = 1;
    step(); step();
    check("rst_mem_valid", mem_valid, 0);
    check("rst_busy", ex_busy, 0);
    reset = 0; ex_valid = 0;
    step();
    check("idle_mem_valid", mem_valid, 0);

    ex_op = ADD; ex_rdata1 = 5; ex_rdata2 = 32'hFFFF_FFFD; ex_valid = 1;
    #1 check("add_stall_pre", ex_stall, 0);
    step();
    ex_valid = 0;
    check("add_valid", mem_valid, 1);
    check("add_data0", mem_data0, 32'h2);
    check("add_data1", mem_data1, 32'hFFFF_FFFD);
    check("add_pc", mem_pc, 32'h40);
    check("add_ctrl", mem_ctrl, 32'h1A5A);
    check("add_stall_post", ex_stall, 0);
    step();
    check("bubble_valid", mem_valid, 0);

    alu(ADD, 1, 5, 7);                       check("sub", mem_data0, 32'hFFFF_FFFE);
    ex_use_imm = 1; ex_imm = 4;
    alu(SR, 1, 32'h8000_0000, 32'h99);       check("sra_imm", mem_data0, 32'hF800_0000);
    check("sra_data1", mem_data1, 32'h99);
    alu(SR, 0, 32'h8000_0000, 0);            check("srl_imm", mem_data0, 32'h0800_0000);
    ex_use_imm = 0; ex_imm = 0;
    alu(SL, 0, 1, 32'h21);                   check("sl_amt_wrap", mem_data0, 32'h2);
    alu(SLT, 0, 32'hFFFF_FFFF, 1);           check("slt", mem_data0, 32'h1);
    alu(SLTU, 0, 32'hFFFF_FFFF, 1);          check("sltu", mem_data0, 32'h0);
    alu(XOR, 0, 32'hF0F0_F0F0, 32'hFF00_FF00); check("xor", mem_data0, 32'h0FF0_0FF0);
    alu(AND, 0, 32'hF0F0_F0F0, 32'hFF00_FF00); check("and", mem_data0, 32'hF000_F000);

    ex_use_pc0 = 1; ex_jmp = 1; ex_use_pc1 = 1; ex_pc = 32'h100; ex_imm = 32'h20;
    alu(ADD, 0, 32'h55, 32'h66);
    check("jal_link", mem_data0, 32'h104);
    check("jal_target", mem_data1, 32'h120);
    ex_use_pc0 = 0; ex_jmp = 0; ex_use_pc1 = 0; ex_pc = 32'h40;
    ex_br = 1; ex_imm = 32'hFFFF_FFF0;
    alu(SEQ, 0, 32'h1000, 32'h1000);
    check("br_cond", mem_data0, 32'h1);
    check("br_target", mem_data1, 32'h0FF0);
    ex_br = 0; ex_imm = 0;

    mem_stall = 1; ex_op = ADD; ex_rdata1 = 9; ex_rdata2 = 9; ex_valid = 1;
    #1 check("stall_ex_stall", ex_stall, 1);
    step();
    check("stall_hold_data0", mem_data0, 32'h1);
    check("stall_hold_valid", mem_valid, 1);
    check("stall_hold_data1", mem_data1, 32'h0FF0);
    mem_stall = 0;
    step();
    ex_valid = 0;
    check("stall_release", mem_data0, 32'd18);

    ex_flush = 1;
    alu(ADD, 0, 1, 1);
    check("flush_alu_valid", mem_valid, 0);
    ex_flush = 0;

`ifdef EX_MDU_EN
    mdu(3'd0, 7, 32'hFFFF_FFFD, lat, res);
    check("mul_latency", lat, 34);
    check("mul", res, 32'hFFFF_FFEB);
    step();
    check("mul_valid_drop", mem_valid, 0);
    check("mul_busy_drop", ex_busy, 0);
    mdu(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, res); check("mulhu", res, 32'hFFFF_FFFE);
    mdu(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, res); check("mulh", res, 32'h0);
    mdu(3'd5, 100, 0, lat, res);                       check("divu_by0", res, 32'hFFFF_FFFF);
    mdu(3'd6, 100, 0, lat, res);                       check("rem_by0", res, 32'd100);
    mdu(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, lat, res); check("div_ovf", res, 32'h8000_0000);
    mdu(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, lat, res); check("rem_ovf", res, 32'h0);
    mdu(3'd4, 32'hFFFF_FFF9, 2, lat, res);             check("div_neg", res, 32'hFFFF_FFFD);

    ex_mdu = 1; ex_mdu_op = 3'd6; ex_rdata1 = 32'hFFFF_FFF9; ex_rdata2 = 2; ex_valid = 1;
    repeat (33) step();
    check("done_busy", ex_busy, 1);
    check("done_no_stall", ex_stall, 0);
    mem_stall = 1;
    seen = 0;
    repeat (3) begin
      step();
      if (mem_valid || !ex_busy || !ex_stall) seen = 1;
    end
    check("done_hold", seen, 0);
    mem_stall = 0;
    step();
    check("rem_stall_valid", mem_valid, 1);
    check("rem_neg", mem_data0, 32'hFFFF_FFFF);
    ex_valid = 0; ex_mdu = 0;
    check("rem_idle", ex_busy, 0);

    ex_mdu = 1; ex_mdu_op = 3'd0; ex_rdata1 = 3; ex_rdata2 = 5; ex_valid = 1;
    repeat (10) step();
    check("busy_before_rst", ex_busy, 1);
    reset = 1; ex_valid = 0; ex_mdu = 0;
    step();
    reset = 0;
    check("rst_abort_busy", ex_busy, 0);
    check("rst_abort_valid", mem_valid, 0);
    alu(ADD, 0, 40, 2);
    check("post_rst_valid", mem_valid, 1);
    check("post_rst_add", mem_data0, 32'd42);

    ex_mdu = 1; ex_mdu_op = 3'd5; ex_rdata1 = 1000; ex_rdata2 = 7; ex_valid = 1;
    repeat (5) step();
    ex_flush = 1;
    step();
    check("flush_busy", ex_busy, 0);
    check("flush_valid", mem_valid, 0);
    ex_flush = 0; ex_valid = 0; ex_mdu = 0;
    seen = 0;
    repeat (40) begin
      step();
      if (mem_valid) seen = 1;
    end
    check("flush_no_result", seen, 0);

    ex_mdu = 1; ex_mdu_op = 3'd0; ex_valid = 1; ex_flush = 1;
    step();
    check("flush_start_busy", ex_busy, 0);
    ex_valid = 0; ex_mdu = 0; ex_flush = 0;
`else
    ex_mdu = 1; ex_mdu_op = 3'd3; ex_op = ADD; ex_rdata1 = 3; ex_rdata2 = 4; ex_valid = 1;
    #1 check("nomdu_stall", ex_stall, 0);
    check("nomdu_busy_pre", ex_busy, 0);
    step();
    ex_valid = 0; ex_mdu = 0;
    check("nomdu_valid", mem_valid, 1);
    check("nomdu_add", mem_data0, 32'd7);
    check("nomdu_busy", ex_busy, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stage_execute_mdu.md
STAGE_EXECUTE_MDU -- requirements
Module: stage_execute_mdu

Interface
REQ-001 SHALL have parameter: XLEN, 32, datapath width (≥8, power of 2).
REQ-002 SHALL have parameter: CTRL_W, 13, width of the opaque mem/wb control bundle passed through.
REQ-003 SHALL have ports: clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports: ex_valid  in  1;  ex_pc, ex_rdata1, ex_rdata2, ex_imm  in  XLEN each  operands.
REQ-006 SHALL have ports: ex_use_pc0, ex_use_pc1, ex_use_imm, ex_sub_sra, ex_jmp, ex_br  in  1 each;  ex_op  in  4  ALU op (NOP/ADD/AND/OR/XOR/SEQ/SLT/SLTU/SL/SR).
REQ-007 SHALL have ports: ex_mdu  in  1  selects multiply/divide unit;  ex_mdu_op  in  3  MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU = 0..7.
REQ-008 SHALL have ports: ex_ctrl  in  CTRL_W  control bundle;  ex_flush  in  1  kill current EX instruction;  mem_stall  in  1.
REQ-009 SHALL have ports: ex_stall  out  1;  ex_busy  out  1  MDU state != IDLE.
REQ-010 SHALL have ports: mem_valid  out  1;  mem_pc, mem_data0, mem_data1  out  XLEN;  mem_ctrl  out  CTRL_W (all registered).

Function
REQ-011 SHALL compute op1 = ex_use_pc0 ? ex_pc : ex_rdata1 and op2 = ex_jmp ? 4 : (ex_use_imm ? ex_imm : ex_rdata2).
REQ-012 SHALL, for non-MDU ops, register the ALU result in mem_data0 one edge after acceptance; ADD negates op2 if ex_sub_sra; SR is arithmetic if ex_sub_sra; shift amount is op2[log2(XLEN)-1:0]; SEQ/SLT/SLTU zero-extend a 1-bit result.
REQ-013 SHALL load mem_data1 with ex_imm + (ex_use_pc1 ? ex_pc : ex_rdata1) when ex_jmp|ex_br, otherwise with ex_rdata2; all arithmetic is modulo 2^XLEN.
REQ-014 SHALL hold mem_valid, mem_pc, mem_data0, mem_data1 and mem_ctrl unchanged on any edge with mem_stall=1.
REQ-015 SHALL, on an edge with mem_stall=0, set mem_valid = ex_valid & ~ex_flush & (~ex_mdu | state==DONE).
REQ-016 SHALL implement MDU FSM IDLE->BUSY->DONE->IDLE with counter width log2(XLEN)+1.
REQ-017 SHALL go IDLE->BUSY when ex_valid & ex_mdu & ~ex_flush, capturing operand magnitudes and sign flags, independent of mem_stall.
REQ-018 SHALL perform one radix-2 shift-add (MUL*) or restoring shift-subtract (DIV*/REM*) step per BUSY cycle, and go to DONE after exactly XLEN steps.
REQ-019 SHALL, in DONE with mem_stall=0, write the sign-corrected result to mem_data0, set mem_valid=1, and go to IDLE on that edge; with mem_stall=1, SHALL remain in DONE.
REQ-020 SHALL make MDU latency XLEN+2 edges from the first edge ex_valid&ex_mdu is seen to mem_valid=1, absent stalls.
REQ-021 SHALL return 2^XLEN-1 for DIV/DIVU by zero and the dividend for REM/REMU by zero.
REQ-022 SHALL return the dividend for signed DIV of -2^(XLEN-1) by -1, and 0 for the corresponding REM.
REQ-023 SHALL take MULH/MULHSU/MULHU from the upper XLEN bits and MUL from the lower XLEN bits of the 2*XLEN product.
REQ-024 SHALL drive ex_stall = ex_valid & (mem_stall | (ex_mdu & state!=DONE)); decode holds all ex_* inputs stable while ex_stall=1.
REQ-025 SHALL, on ex_flush=1, return the FSM to IDLE on the next edge from any state, and the flushed instruction SHALL never produce mem_valid=1.
REQ-026 SHALL give ex_flush priority over a simultaneous MDU start or DONE write.

Reset
REQ-027 SHALL, when reset=1 at an edge, set mem_valid=0, state=IDLE and counter=0, aborting any MDU operation in progress.
REQ-028 SHALL leave data registers (mem_pc, mem_data0/1, mem_ctrl, MDU datapath) unreset; they are don't-care while mem_valid=0.

Configuration
REQ-029 SHALL, with EX_MDU_EN defined, include the MDU and FSM as specified.
REQ-030 SHALL, with EX_MDU_EN undefined, omit the MDU logic: ex_mdu and ex_mdu_op are ignored, all ops complete in one edge per REQ-012, and ex_busy is constant 0.

Verification
REQ-031 SHALL verify: ADD op1=5, op2=0xFFFFFFFD, mem_stall=0 -> mem_valid=1 and mem_data0=0x00000002 after 1 edge, ex_stall=0 throughout.
REQ-032 SHALL verify: MUL 7 × 0xFFFFFFFD -> mem_data0=0xFFFFFFEB exactly 34 edges after first presentation; MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
REQ-033 SHALL verify: DIVU 100/0 -> 0xFFFFFFFF; REM 100/0 -> 100; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
REQ-034 SHALL verify: DIV -7/2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF; with mem_stall=1 for 3 cycles in DONE -> state stays DONE, mem_valid rises on the first edge after mem_stall falls.
REQ-035 SHALL verify: reset asserted on the 10th BUSY cycle -> next edge state=IDLE, mem_valid=0; a following ADD completes normally in 1 edge.
REQ-036 SHALL verify: ex_flush during BUSY -> IDLE on next edge, no mem_valid for that instruction; EX_MDU_EN undefined -> ex_busy=0, ex_mdu=1 executes ex_op in 1 edge.
